pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/dlx_pkg.sv | 10 +
 rtl/pipe_ctrl_hazard_detect.sv | 15 +
 rtl/pipe_ctrl.sv | 126 ++++++++++++
 tb/tb_pipe_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/dlx_pkg.sv
// dlx_pkg: shared pipeline-control types (controller state encoding, register index).
package dlx_pkg;
    typedef logic [4:0] reg_idx_t;
    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        FLUSH      = 2'd2,
        MEM_WAIT   = 2'd3
    } ctrl_state_t;
endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// hazard_detect: combinational load-use hazard check between the ID sources and the EX load destination.
module hazard_detect
    import dlx_pkg::*;
(
    input  reg_idx_t i_rs1,
    input  reg_idx_t i_rs2,
    input  logic     i_rs1_used,
    input  logic     i_rs2_used,
    input  reg_idx_t i_rd,
    input  logic     i_load,
    output logic     o_hazard
);
    assign o_hazard = i_load && i_rd != '0 &&
                      ((i_rs1_used && i_rs1 == i_rd) || (i_rs2_used && i_rs2 == i_rd));
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: DLX pipeline stall/flush controller with memory-wait freeze.
// Define PIPE_CTRL_PERF_EN to build the saturating stall/flush performance counters.
module pipe_ctrl
    import dlx_pkg::*;
#(
    parameter int LOAD_LAT     = 1,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  reg_idx_t    Rs1_ID,
    input  reg_idx_t    Rs2_ID,
    input  logic        rs1_used_ID,
    input  logic        rs2_used_ID,
    input  reg_idx_t    Rd_EX,
    input  logic        d_load_enable_EX,
    input  logic        pc_cmd_EX,
    input  logic        d_ready,
    output logic        hold_IF,
    output logic        hold_ID,
    output logic        bubble_EX,
    output logic        flush_ID,
    output logic        hold_EX,
    output logic [1:0]  ctrl_state,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);
    ctrl_state_t r_state, r_saved, w_eff, w_next_state, w_next_saved;
    logic [2:0]  r_cnt, w_next_cnt;
    logic        w_hazard, w_hold_if, w_hold_id, w_bubble, w_flush, w_hold_ex;

    hazard_detect u_hazard (
        .i_rs1      (Rs1_ID),
        .i_rs2      (Rs2_ID),
        .i_rs1_used (rs1_used_ID),
        .i_rs2_used (rs2_used_ID),
        .i_rd       (Rd_EX),
        .i_load     (d_load_enable_EX),
        .o_hazard   (w_hazard)
    );

    // While frozen, the interrupted state drives behaviour as soon as memory is ready again.
    assign w_eff = (r_state == MEM_WAIT) ? r_saved : r_state;

    always_comb begin
        w_hold_if    = 1'b0;
        w_hold_id    = 1'b0;
        w_bubble     = 1'b0;
        w_flush      = 1'b0;
        w_hold_ex    = 1'b0;
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_next_saved = r_saved;
        if (!d_ready) begin
            w_hold_if    = 1'b1;
            w_hold_id    = 1'b1;
            w_hold_ex    = 1'b1;
            w_next_state = MEM_WAIT;
            w_next_saved = w_eff;
        end else if (w_eff == LOAD_STALL || w_eff == FLUSH) begin
            w_hold_if    = (w_eff == LOAD_STALL);
            w_hold_id    = (w_eff == LOAD_STALL);
            w_flush      = (w_eff == FLUSH);
            w_bubble     = 1'b1;
            w_next_cnt   = r_cnt - 3'd1;
            w_next_state = (r_cnt == 3'd1) ? RUN : w_eff;
        end else if (pc_cmd_EX) begin
            w_flush      = 1'b1;
            w_bubble     = 1'b1;
            w_next_state = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
            w_next_cnt   = 3'(FLUSH_CYCLES - 1);
        end else if (w_hazard) begin
            w_hold_if    = 1'b1;
            w_hold_id    = 1'b1;
            w_bubble     = 1'b1;
            w_next_state = (LOAD_LAT > 1) ? LOAD_STALL : RUN;
            w_next_cnt   = 3'(LOAD_LAT - 1);
        end else begin
            w_next_state = RUN;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= RUN;
            r_saved <= RUN;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_next_state;
            r_saved <= w_next_saved;
            r_cnt   <= w_next_cnt;
        end
    end

    assign hold_IF    = w_hold_if & ~reset;
    assign hold_ID    = w_hold_id & ~reset;
    assign bubble_EX  = w_bubble  & ~reset;
    assign flush_ID   = w_flush   & ~reset;
    assign hold_EX    = w_hold_ex & ~reset;
    assign ctrl_state = r_state;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] r_stall_cnt, r_flush_cnt;
    logic        w_branch;

    assign w_branch = d_ready && w_eff == RUN && pc_cmd_EX;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_hold_id && r_stall_cnt != '1)
                r_stall_cnt <= r_stall_cnt + 32'd1;
            if (w_branch && r_flush_cnt != '1)
                r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: three parameterisations of pipe_ctrl checked every cycle against a remaining-cycles model.
module tb_pipe_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  r1, r2, rd;
    logic        u1, u2, ld, pc, dr;
    logic        hif[3], hid[3], bex[3], fid[3], hex[3];
    logic [1:0]  st[3];
    logic [31:0] scnt[3], fcnt[3];

    int    n_chk = 0, n_pass = 0;
    int    lat[3] = '{1, 3, 5};
    int    fl_cyc[3] = '{2, 2, 1};
    int    sl[3] = '{0, 0, 0};
    int    fl[3] = '{0, 0, 0};
    bit    mw[3] = '{0, 0, 0};
    logic [31:0] sc[3] = '{0, 0, 0};
    logic [31:0] fc[3] = '{0, 0, 0};

    always #5 clk = ~clk;

    pipe_ctrl #(.LOAD_LAT(1), .FLUSH_CYCLES(2)) dut_a (
        .clk(clk), .reset(reset), .Rs1_ID(r1), .Rs2_ID(r2), .rs1_used_ID(u1), .rs2_used_ID(u2),
        .Rd_EX(rd), .d_load_enable_EX(ld), .pc_cmd_EX(pc), .d_ready(dr),
        .hold_IF(hif[0]), .hold_ID(hid[0]), .bubble_EX(bex[0]), .flush_ID(fid[0]), .hold_EX(hex[0]),
        .ctrl_state(st[0]), .stall_cnt(scnt[0]), .flush_cnt(fcnt[0]));

    pipe_ctrl #(.LOAD_LAT(3), .FLUSH_CYCLES(2)) dut_b (
        .clk(clk), .reset(reset), .Rs1_ID(r1), .Rs2_ID(r2), .rs1_used_ID(u1), .rs2_used_ID(u2),
        .Rd_EX(rd), .d_load_enable_EX(ld), .pc_cmd_EX(pc), .d_ready(dr),
        .hold_IF(hif[1]), .hold_ID(hid[1]), .bubble_EX(bex[1]), .flush_ID(fid[1]), .hold_EX(hex[1]),
        .ctrl_state(st[1]), .stall_cnt(scnt[1]), .flush_cnt(fcnt[1]));

    pipe_ctrl #(.LOAD_LAT(5), .FLUSH_CYCLES(1)) dut_c (
        .clk(clk), .reset(reset), .Rs1_ID(r1), .Rs2_ID(r2), .rs1_used_ID(u1), .rs2_used_ID(u2),
        .Rd_EX(rd), .d_load_enable_EX(ld), .pc_cmd_EX(pc), .d_ready(dr),
        .hold_IF(hif[2]), .hold_ID(hid[2]), .bubble_EX(bex[2]), .flush_ID(fid[2]), .hold_EX(hex[2]),
        .ctrl_state(st[2]), .stall_cnt(scnt[2]), .flush_cnt(fcnt[2]));

    task automatic pin(input string n, input logic [31:0] a, input logic [31:0] w);
        n_chk++;
        if (a === w) n_pass++;
        else $display("FAIL %s got %h want %h", n, a, w);
    endtask

    function automatic bit hazard();
        return ld && rd != 5'd0 && ((u1 && r1 == rd) || (u2 && r2 == rd));
    endfunction

    // Model: remaining stall/flush cycles plus a "memory was not ready last cycle" flag.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            logic [6:0] e;
            logic [1:0] es;
            bit br;
            br = 1'b0;
            es = mw[k] ? 2'd3 : (sl[k] > 0) ? 2'd1 : (fl[k] > 0) ? 2'd2 : 2'd0;
            if (reset)               e = 7'b0;
            else if (!dr)            e = {5'b11001, es};
            else if (sl[k] > 0)      e = {5'b11100, es};
            else if (fl[k] > 0)      e = {5'b00110, es};
            else if (pc) begin       e = {5'b00110, es}; br = 1'b1; end
            else if (hazard())       e = {5'b11100, es};
            else                     e = {5'b00000, es};
            pin($sformatf("ctrl[%0d]", k), {25'b0, hif[k], hid[k], bex[k], fid[k], hex[k], st[k]}, {25'b0, e});
`ifdef PIPE_CTRL_PERF_EN
            pin($sformatf("stall_cnt[%0d]", k), scnt[k], reset ? 32'd0 : sc[k]);
            pin($sformatf("flush_cnt[%0d]", k), fcnt[k], reset ? 32'd0 : fc[k]);
            if (e[5] && sc[k] != 32'hFFFFFFFF) sc[k] = sc[k] + 1;
            if (br && fc[k] != 32'hFFFFFFFF) fc[k] = fc[k] + 1;
`else
            pin($sformatf("stall_cnt[%0d]", k), scnt[k], 32'd0);
            pin($sformatf("flush_cnt[%0d]", k), fcnt[k], 32'd0);
`endif
            if (reset) begin
                sl[k] = 0; fl[k] = 0; mw[k] = 1'b0; sc[k] = 0; fc[k] = 0;
            end else begin
                mw[k] = !dr;
                if (dr) begin
                    if (sl[k] > 0)      sl[k]--;
                    else if (fl[k] > 0) fl[k]--;
                    else if (pc)        fl[k] = fl_cyc[k] - 1;
                    else if (hazard())  sl[k] = lat[k] - 1;
                end
            end
        end
    end

    task automatic drive(input logic [4:0] a, input logic ua, input logic [4:0] b, input logic ub,
                         input logic [4:0] d, input logic l, input logic p, input logic r);
        r1 = a; u1 = ua; r2 = b; u2 = ub; rd = d; ld = l; pc = p; dr = r;
    endtask

    task automatic idle();
        drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset = 1'b1;
        drive(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        pin("rst_outs", {hif[0], hid[0], bex[0], fid[0], hex[0], st[0]}, 0);
        step(1);
        idle();
        step(1);
        reset = 1'b0;
        step(2);
        // load-use hazard on rs1
        drive(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        pin("lat1_hold", {hif[0], hid[0], bex[0]}, 3'b111);
        pin("lat1_state", st[0], 0);
        pin("lat3_st_c0", st[1], 0);
        step(1);
        idle();
        @(negedge clk);
        pin("lat1_done", hif[0], 0);
        pin("lat3_st_c1", {st[1], hif[1]}, 3'b011);
        step(1);
        @(negedge clk);
        pin("lat3_st_c2", {st[1], hif[1]}, 3'b011);
        step(1);
        @(negedge clk);
        pin("lat3_st_c3", {st[1], hif[1]}, 3'b000);
        pin("lat5_still", {st[2], hif[2]}, 3'b011);
        step(3);
        drive(5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        pin("rd0_nostall", hif[0], 0);
        step(1);
        drive(5'd3, 1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        pin("rs2_haz", bex[0], 1);
        step(1);
        idle();
        step(6);
        drive(5'd3, 1'b1, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        pin("rs2_unused", hif[0], 0);
        step(1);
        drive(5'd7, 1'b1, 5'd0, 1'b0, 5'd7, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        pin("not_load", bex[0], 0);
        step(1);
        idle();
        step(2);
        // taken branch beats a simultaneous hazard
        drive(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        pin("br_flush", {fid[0], bex[0], hif[0]}, 3'b110);
        step(1);
        idle();
        @(negedge clk);
        pin("br_flush2", {fid[0], st[0]}, 3'b110);
        pin("br_fc1_done", fid[2], 0);
        step(1);
        @(negedge clk);
        pin("br_end", {fid[0], st[0]}, 3'b000);
        step(2);
        // memory wait during the first FLUSH cycle
        drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        step(1);
        drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        pin("mw_hold", {hif[0], hid[0], hex[0], fid[0], bex[0], st[0]}, 7'b1110010);
        step(3);
        @(negedge clk);
        pin("mw_state", {hex[0], st[0]}, 3'b111);
        step(1);
        idle();
        @(negedge clk);
        pin("mw_resume", {fid[0], hex[0], st[0]}, 4'b1011);
        step(1);
        @(negedge clk);
        pin("mw_done", {fid[0], st[0]}, 3'b000);
        step(2);
        // reset in the middle of a LOAD_STALL
        drive(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1);
        step(1);
        idle();
        step(1);
        reset = 1'b1;
        drive(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        pin("rst_mid", {hif[2], hid[2], bex[2], fid[2], hex[2], st[2]}, 0);
        step(1);
        reset = 1'b0;
        idle();
        @(negedge clk);
        pin("rst_release", {st[2], hif[2], bex[2]}, 0);
        step(2);
        for (int i = 0; i < 80; i++) begin
            drive(5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0);
            step(1);
        end
        idle();
        step(8);
`ifdef PIPE_CTRL_PERF_EN
        force dut_a.r_stall_cnt = 32'hFFFFFFFE;
        sc[0] = 32'hFFFFFFFE;
        #1;
        release dut_a.r_stall_cnt;
        drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        step(3);
        idle();
        @(negedge clk);
        pin("stall_sat", scnt[0], 32'hFFFFFFFF);
        step(1);
`else
        drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        step(3);
        idle();
        @(negedge clk);
        pin("perf_off", scnt[0] | fcnt[0], 0);
        step(1);
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
